// File: rtl/vga_code_if.sv
// Write-request bundle between the two colour requesters and vga_code_ctrl.
// A requester holds req, half and data stable until it sees its ack high for one cycle.
interface vga_code_if;
  logic        req0;
  logic        req1;
  logic        half0;
  logic        half1;
  logic [11:0] data0;
  logic [11:0] data1;
  logic        ack0;
  logic        ack1;

  modport master (
    output req0, req1, half0, half1, data0, data1,
    input  ack0, ack1
  );

  modport slave (
    input  req0, req1, half0, half1, data0, data1,
    output ack0, ack1
  );
endinterface

// File: rtl/vga_code_ctrl.sv
// Arbitrates half-screen colour writes into a staging register and commits
// staging to the VGA code bus only on (every DIV-th) vsync rising edge.
module vga_code_ctrl #(
  parameter int          DIV       = 1,
  parameter logic [23:0] INIT_CODE = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              hold,
  vga_code_if.slave         bus,
  output logic [23:0]       code,
  output logic              pending,
  output logic              frame_tick
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  logic [11:0] stage_l;
  logic [11:0] stage_r;
  logic        vsync_q;
  logic [7:0]  frame_cnt;
  logic        last_grant;   // 1 = requester 1 was granted last

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;
  logic edge_det;
  logic slot;
  logic commit;

  // A requester whose ack is high this cycle is still holding req from the
  // granted write, so it is masked to avoid a double grant.
  always_comb begin
    elig0    = bus.req0 & ~bus.ack0;
    elig1    = bus.req1 & ~bus.ack1;
    grant0   = elig0 & (~elig1 | last_grant);
    grant1   = elig1 & (~elig0 | ~last_grant);
    edge_det = vsync & ~vsync_q;
    slot     = edge_det && (frame_cnt == DIV_M1);
    commit   = slot & ~hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_l    <= INIT_CODE[23:12];
      stage_r    <= INIT_CODE[11:0];
      code       <= INIT_CODE;
      vsync_q    <= 1'b1;
      frame_cnt  <= 8'd0;
      last_grant <= 1'b1;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= edge_det;
      bus.ack0   <= grant0;
      bus.ack1   <= grant1;

      if (grant0) begin
        last_grant <= 1'b0;
        if (bus.half0) stage_r <= bus.data0;
        else           stage_l <= bus.data0;
      end else if (grant1) begin
        last_grant <= 1'b1;
        if (bus.half1) stage_r <= bus.data1;
        else           stage_l <= bus.data1;
      end

      if (edge_det) begin
        if (slot) frame_cnt <= 8'd0;
        else      frame_cnt <= frame_cnt + 8'd1;
      end

      // Commit copies staging as it was before any write landing this edge.
      if (commit) code <= {stage_l, stage_r};

      if (grant0 | grant1) pending <= 1'b1;
      else if (commit)     pending <= 1'b0;
    end
  end

endmodule
